// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the pipeline hazard controller.
//   state_e : FSM state encoding (RUN, D_WAIT, MD_WAIT).
//   act_e   : pipeline-control action. Its numeric value is the action's
//             priority rank, so a higher value always wins.
//   ctrl_t  : the eight stall/flush controls as one packed bundle.
//   act_ctrl: maps an action to its stall/flush pattern.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_D_WAIT  = 2'd1,
    ST_MD_WAIT = 2'd2
  } state_e;

  // Priority order: D-miss > MD_WAIT > branch > load-use > I-miss.
  typedef enum logic [2:0] {
    ACT_NONE     = 3'd0,
    ACT_IMISS    = 3'd1,
    ACT_LOAD_USE = 3'd2,
    ACT_BRANCH   = 3'd3,
    ACT_MD       = 3'd4,
    ACT_DMISS    = 3'd5
  } act_e;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic idex_stall;
    logic exmem_stall;
    logic memwb_stall;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } ctrl_t;

  // A stage is never both stalled and flushed by any single action.
  function automatic ctrl_t act_ctrl(input act_e act);
    ctrl_t c;
    c = '0;
    case (act)
      ACT_DMISS: begin
        c.pc_stall    = 1'b1;
        c.ifid_stall  = 1'b1;
        c.idex_stall  = 1'b1;
        c.exmem_stall = 1'b1;
        c.memwb_stall = 1'b1;
      end
      ACT_MD: begin
        // Front of the pipe holds; a bubble goes down behind the EX op.
        c.pc_stall    = 1'b1;
        c.ifid_stall  = 1'b1;
        c.idex_stall  = 1'b1;
        c.exmem_flush = 1'b1;
      end
      ACT_BRANCH: begin
        c.ifid_flush = 1'b1;
        c.idex_flush = 1'b1;
      end
      ACT_LOAD_USE: begin
        c.pc_stall   = 1'b1;
        c.ifid_stall = 1'b1;
        c.idex_flush = 1'b1;
      end
      ACT_IMISS: begin
        c.pc_stall   = 1'b1;
        c.ifid_flush = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: compares the EX destination register against every valid
// ID source operand.
//   dst     : EX destination register
//   src     : packed ID source registers, slot k at [k*ADDR_W +: ADDR_W]
//   src_vld : per-slot valid
//   match   : 1 when any valid slot equals dst and dst is not register 0
module hazard_cmp #(
  parameter int ADDR_W  = 4,
  parameter int NUM_SRC = 2
) (
  input  logic [ADDR_W-1:0]         dst,
  input  logic [NUM_SRC*ADDR_W-1:0] src,
  input  logic [NUM_SRC-1:0]        src_vld,
  output logic                      match
);

  always_comb begin
    match = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_vld[k] && (src[k*ADDR_W +: ADDR_W] == dst)) match = 1'b1;
    end
    // Register 0 is hard-wired, so writing it never creates a dependency.
    if (dst == '0) match = 1'b0;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller.
//   clk, rst_n            : clock, asynchronous active-low reset
//   d_req, d_hit          : MEM-stage access and D-cache hit
//   i_hit                 : I-cache hit for the current fetch
//   ld_ex, st_id          : EX op is a load, ID op is a store
//   dst_ex, src_id,
//   src_vld_id            : register numbers for load-use detection
//   md_start_ex           : multi-cycle op entering EX
//   br_taken_ex           : taken branch resolved in EX
//   *_stall, *_flush      : per-stage hold / bubble controls (combinational)
//   md_busy               : multi-cycle op in progress (also while frozen)
//   dmiss_cnt             : cycles of the current or last D-miss (saturating)
//   timeout               : sticky D-miss watchdog flag
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int NUM_SRC = 2,
  parameter int MD_LAT  = 4,
  parameter int DTMO    = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      d_req,
  input  logic                      d_hit,
  input  logic                      i_hit,
  input  logic                      ld_ex,
  input  logic                      st_id,
  input  logic [ADDR_W-1:0]         dst_ex,
  input  logic [NUM_SRC*ADDR_W-1:0] src_id,
  input  logic [NUM_SRC-1:0]        src_vld_id,
  input  logic                      md_start_ex,
  input  logic                      br_taken_ex,
  output logic                      PC_stall,
  output logic                      IFID_stall,
  output logic                      IDEX_stall,
  output logic                      EXMEM_stall,
  output logic                      MEMWB_stall,
  output logic                      IFID_flush,
  output logic                      IDEX_flush,
  output logic                      EXMEM_flush,
  output logic                      md_busy,
  output logic [7:0]                dmiss_cnt,
  output logic                      timeout
);

  localparam logic [3:0] MD_INIT = 4'(MD_LAT - 1);

  state_e     state;
  logic [3:0] md_cnt;
  logic       dmiss;
  logic       lu_match;
  logic [7:0] cnt_nxt;
  act_e       act;
  ctrl_t      ctrl;

  hazard_cmp #(
    .ADDR_W (ADDR_W),
    .NUM_SRC(NUM_SRC)
  ) u_cmp (
    .dst    (dst_ex),
    .src    (src_id),
    .src_vld(src_vld_id),
    .match  (lu_match)
  );

  assign dmiss   = d_req & ~d_hit;
  assign cnt_nxt = (dmiss_cnt == 8'hFF) ? 8'hFF : dmiss_cnt + 8'd1;

  // Highest-priority event picks the action. Held in reset so no control
  // leaks out while the pipeline is being cleared.
  always_comb begin
    act = ACT_NONE;
    if (!rst_n)                                   act = ACT_NONE;
    else if (state == ST_D_WAIT || dmiss)         act = ACT_DMISS;
    else if (state == ST_MD_WAIT)                 act = ACT_MD;
    else if (br_taken_ex)                         act = ACT_BRANCH;
    else if (ld_ex && !st_id && lu_match)         act = ACT_LOAD_USE;
    else if (!i_hit)                              act = ACT_IMISS;
  end

  assign ctrl        = act_ctrl(act);
  assign PC_stall    = ctrl.pc_stall;
  assign IFID_stall  = ctrl.ifid_stall;
  assign IDEX_stall  = ctrl.idex_stall;
  assign EXMEM_stall = ctrl.exmem_stall;
  assign MEMWB_stall = ctrl.memwb_stall;
  assign IFID_flush  = ctrl.ifid_flush;
  assign IDEX_flush  = ctrl.idex_flush;
  assign EXMEM_flush = ctrl.exmem_flush;

  // md_cnt is only nonzero while an MD op is pending, so a D_WAIT with a
  // nonzero count is an MD op frozen behind a D-miss.
  assign md_busy = (state == ST_MD_WAIT) || (state == ST_D_WAIT && md_cnt != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      md_cnt    <= 4'd0;
      dmiss_cnt <= 8'd0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (dmiss) begin
            state     <= ST_D_WAIT;
            dmiss_cnt <= 8'd0;
          end else if (md_start_ex) begin
            state  <= ST_MD_WAIT;
            md_cnt <= MD_INIT;
          end
        end
        ST_MD_WAIT: begin
          if (dmiss) begin
            // md_cnt is left untouched: the MD op resumes after the miss.
            state     <= ST_D_WAIT;
            dmiss_cnt <= 8'd0;
          end else if (md_cnt <= 4'd1) begin
            state  <= ST_RUN;
            md_cnt <= 4'd0;
          end else begin
            md_cnt <= md_cnt - 4'd1;
          end
        end
        ST_D_WAIT: begin
          dmiss_cnt <= cnt_nxt;
          if (int'({24'd0, cnt_nxt}) == DTMO) timeout <= 1'b1;
          if (d_hit) state <= (md_cnt != 4'd0) ? ST_MD_WAIT : ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios followed by randomized traffic, every
// cycle compared against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int ADDR_W  = 4;
  localparam int NUM_SRC = 2;
  localparam int MD_LAT  = 4;
  localparam int DTMO    = 255;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      d_req, d_hit, i_hit, ld_ex, st_id;
  logic [ADDR_W-1:0]         dst_ex;
  logic [NUM_SRC*ADDR_W-1:0] src_id;
  logic [NUM_SRC-1:0]        src_vld_id;
  logic                      md_start_ex, br_taken_ex;
  logic                      PC_stall, IFID_stall, IDEX_stall, EXMEM_stall, MEMWB_stall;
  logic                      IFID_flush, IDEX_flush, EXMEM_flush;
  logic                      md_busy;
  logic [7:0]                dmiss_cnt;
  logic                      timeout;

  int checks   = 0;
  int failures = 0;

  // Model state: pending D-miss, remaining MD hold cycles, miss counter.
  bit m_dwait;
  int m_md_rem;
  int m_cnt;
  bit m_to;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  hazard_ctrl #(
    .ADDR_W (ADDR_W),
    .NUM_SRC(NUM_SRC),
    .MD_LAT (MD_LAT),
    .DTMO   (DTMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_req      (d_req),
    .d_hit      (d_hit),
    .i_hit      (i_hit),
    .ld_ex      (ld_ex),
    .st_id      (st_id),
    .dst_ex     (dst_ex),
    .src_id     (src_id),
    .src_vld_id (src_vld_id),
    .md_start_ex(md_start_ex),
    .br_taken_ex(br_taken_ex),
    .PC_stall   (PC_stall),
    .IFID_stall (IFID_stall),
    .IDEX_stall (IDEX_stall),
    .EXMEM_stall(EXMEM_stall),
    .MEMWB_stall(MEMWB_stall),
    .IFID_flush (IFID_flush),
    .IDEX_flush (IDEX_flush),
    .EXMEM_flush(EXMEM_flush),
    .md_busy    (md_busy),
    .dmiss_cnt  (dmiss_cnt),
    .timeout    (timeout)
  );

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dwait  = 1'b0;
    m_md_rem = 0;
    m_cnt    = 0;
    m_to     = 1'b0;
  endtask

  function automatic bit load_use();
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++)
      if (src_vld_id[k] && src_id[k*ADDR_W +: ADDR_W] == dst_ex && dst_ex != 0) hit = 1'b1;
    return ld_ex && !st_id && hit;
  endfunction

  // Advance the model by one clock using the inputs of that cycle.
  task automatic model_update();
    if (m_dwait) begin
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      if (m_cnt == DTMO) m_to = 1'b1;
      if (d_hit) m_dwait = 1'b0;
    end else if (d_req && !d_hit) begin
      m_dwait = 1'b1;
      m_cnt   = 0;
    end else if (m_md_rem > 0) begin
      m_md_rem--;
    end else if (md_start_ex) begin
      m_md_rem = MD_LAT - 1;
    end
  endtask

  // One cycle: check outputs mid-cycle, then clock the model.
  task automatic step();
    logic [4:0] e_st;
    logic [2:0] e_fl;
    @(negedge clk);
    if (!rst_n) model_reset();
    e_st = 5'b0;
    e_fl = 3'b0;
    if (!rst_n) begin
      e_st = 5'b0;
    end else if (m_dwait || (d_req && !d_hit)) begin
      e_st = 5'b11111;
    end else if (m_md_rem > 0) begin
      e_st = 5'b11100; e_fl = 3'b001;
    end else if (br_taken_ex) begin
      e_fl = 3'b110;
    end else if (load_use()) begin
      e_st = 5'b11000; e_fl = 3'b010;
    end else if (!i_hit) begin
      e_st = 5'b10000; e_fl = 3'b100;
    end
    check_eq("stalls", 32'({PC_stall, IFID_stall, IDEX_stall, EXMEM_stall, MEMWB_stall}), 32'(e_st));
    check_eq("flushes", 32'({IFID_flush, IDEX_flush, EXMEM_flush}), 32'(e_fl));
    check_eq("md_busy", 32'(md_busy), 32'(m_md_rem > 0));
    check_eq("dmiss_cnt", 32'(dmiss_cnt), 32'(m_cnt));
    check_eq("timeout", 32'(timeout), 32'(m_to));
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    d_req = 1'b0; d_hit = 1'b1; i_hit = 1'b1; ld_ex = 1'b0; st_id = 1'b0;
    dst_ex = '0; src_id = '0; src_vld_id = '0; md_start_ex = 1'b0; br_taken_ex = 1'b0;
  endtask

  task automatic set_load_use(input logic [3:0] dst, input logic st);
    ld_ex = 1'b1; st_id = st; dst_ex = dst;
    src_id = {4'd5, 4'd2}; src_vld_id = 2'b10;
  endtask

  task automatic drive_random();
    d_req       = ($urandom_range(0, 4) == 0);
    d_hit       = ($urandom_range(0, 2) != 0);
    i_hit       = ($urandom_range(0, 3) != 0);
    ld_ex       = $urandom_range(0, 1) == 1;
    st_id       = ($urandom_range(0, 3) == 0);
    dst_ex      = 4'($urandom_range(0, 3));
    src_id      = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
    src_vld_id  = 2'($urandom_range(0, 3));
    md_start_ex = ($urandom_range(0, 7) == 0);
    br_taken_ex = ($urandom_range(0, 7) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    idle();
    rst_n = 1'b0;
    #1;
    step();
    step();
    rst_n = 1'b1;
    step();

    // D-miss of 3 cycles then hit: four stall cycles, count ends at 3.
    d_req = 1'b1; d_hit = 1'b0;
    repeat (3) step();
    d_hit = 1'b1;
    step();
    idle();
    step();
    check_eq("dmiss_cnt_after_miss", 32'(dmiss_cnt), 32'd3);

    // Load-use hit, then the store and register-0 exemptions.
    set_load_use(4'd5, 1'b0); step();
    idle(); step();
    set_load_use(4'd5, 1'b1); step();
    set_load_use(4'd0, 1'b0); src_id = '0; src_vld_id = 2'b11; step();
    idle(); step();

    // Multi-cycle op alone.
    md_start_ex = 1'b1; step();
    md_start_ex = 1'b0; repeat (4) step();

    // Multi-cycle op interrupted by a 2-cycle D-miss on its 2nd cycle.
    md_start_ex = 1'b1; step();
    md_start_ex = 1'b0; step();
    d_req = 1'b1; d_hit = 1'b0; repeat (2) step();
    d_hit = 1'b1; step();
    idle(); repeat (4) step();

    // Branch and load-use together: branch wins.
    set_load_use(4'd5, 1'b0); br_taken_ex = 1'b1; step();
    idle(); step();

    // Long miss: watchdog, saturation, then reset in the middle of it.
    d_req = 1'b1; d_hit = 1'b0;
    repeat (300) step();
    check_eq("timeout_long_miss", 32'(timeout), 32'd1);
    check_eq("dmiss_cnt_sat", 32'(dmiss_cnt), 32'd255);
    rst_n = 1'b0; step(); step();
    rst_n = 1'b1; idle(); step(); step();

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      step();
    end
    rst_n = 1'b1;
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
